// File: rtl/mem_access_pkg.sv
// Shared op encodings, FSM states and small decode helpers for the MEM stage.
// Imported by mem_access and mem_load_ext.
package mem_access_pkg;

    localparam int OpLen = 6;
    typedef logic [OpLen-1:0] op_t;

    localparam op_t OP_NOP   = 6'd0;
    localparam op_t OP_LUI   = 6'd1;
    localparam op_t OP_AUIPC = 6'd2;
    localparam op_t OP_JAL   = 6'd3;
    localparam op_t OP_JALR  = 6'd4;
    localparam op_t OP_BEQ   = 6'd5;
    localparam op_t OP_BNE   = 6'd6;
    localparam op_t OP_BLT   = 6'd7;
    localparam op_t OP_BGE   = 6'd8;
    localparam op_t OP_BLTU  = 6'd9;
    localparam op_t OP_BGEU  = 6'd10;
    localparam op_t OP_LB    = 6'd11;
    localparam op_t OP_LH    = 6'd12;
    localparam op_t OP_LW    = 6'd13;
    localparam op_t OP_LBU   = 6'd14;
    localparam op_t OP_LHU   = 6'd15;
    localparam op_t OP_SB    = 6'd16;
    localparam op_t OP_SH    = 6'd17;
    localparam op_t OP_SW    = 6'd18;
    localparam op_t OP_ADD   = 6'd19;
    localparam op_t OP_SUB   = 6'd20;
    localparam op_t OP_SLL   = 6'd21;
    localparam op_t OP_SLT   = 6'd22;
    localparam op_t OP_SLTU  = 6'd23;
    localparam op_t OP_XOR   = 6'd24;
    localparam op_t OP_SRL   = 6'd25;
    localparam op_t OP_SRA   = 6'd26;
    localparam op_t OP_OR    = 6'd27;
    localparam op_t OP_AND   = 6'd28;

    localparam logic        True        = 1'b1;
    localparam logic        False       = 1'b0;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic [4:0]  RegAddrZero = 5'd0;

    // Access size in bytes
    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} ma_state_t;

    function automatic logic op_is_load(input op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic op_is_store(input op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_is_mem(input op_t op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    function automatic logic op_is_branch(input op_t op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic op_writes_rd(input op_t op);
        return !(op_is_store(op) || op_is_branch(op) || (op == OP_NOP));
    endfunction

    function automatic logic [2:0] op_size(input op_t op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            OP_LW, OP_SW:         return SIZE_W;
            default:              return SIZE_B;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load extension: assembled little-endian bytes -> register word.
// Kept standalone so a future data cache can reuse it.
module mem_load_ext
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [OpLen-1:0]  i_op,
    input  logic [DATA_W-1:0] i_buf,
    output logic [DATA_W-1:0] o_word
);

    logic signed [7:0]  w_byte_s;
    logic signed [15:0] w_half_s;

    assign w_byte_s = $signed(i_buf[7:0]);
    assign w_half_s = $signed(i_buf[15:0]);

    always_comb begin
        o_word = i_buf;
        case (i_op)
            OP_LB:   o_word = DATA_W'(w_byte_s);
            OP_LH:   o_word = DATA_W'(w_half_s);
            OP_LBU:  o_word = DATA_W'(i_buf[7:0]);
            OP_LHU:  o_word = DATA_W'(i_buf[15:0]);
            default: o_word = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I MEM stage: ALU results pass through in one cycle; loads/stores run
// byte-serially on the shared 8-bit RAM port while upstream is stalled.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              in_valid,
    input  logic [OpLen-1:0]  in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_rd,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_stall
);

    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("mem_access supports only RD_LAT = 1");
    end

    ma_state_t         r_state, w_state_nxt;
    op_t               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [4:0]        r_rd;
    logic [2:0]        r_k;
    logic              r_cap_pend;
    logic [1:0]        r_cap_idx;
    logic [DATA_W-1:0] r_buf;
    logic              r_wb_valid;
    logic              r_wb_we;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic [2:0]        w_last_k;
    logic              w_accept_mem;
    logic [DATA_W-1:0] w_ext;

    assign w_last_k     = op_size(r_op) - 3'd1;
    assign w_accept_mem = (r_state == IDLE) && in_valid && op_is_mem(in_op);

    mem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .i_op   (r_op),
        .i_buf  (r_buf),
        .o_word (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Control and pass-through result registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= 3'd0;
            r_cap_pend <= False;
            r_wb_valid <= False;
            r_wb_we    <= False;
            r_wb_rd    <= RegAddrZero;
            r_wb_data  <= '0;
        end else if (rdy) begin
            r_wb_valid <= False;
            r_wb_we    <= False;
            r_cap_pend <= (r_state == ISSUE) && mem_gnt && op_is_load(r_op);
            if (r_state == IDLE && in_valid) begin
                if (op_is_mem(in_op)) begin
                    r_k <= 3'd0;
                end else begin
                    r_wb_valid <= True;
                    r_wb_we    <= (in_rd != RegAddrZero) && op_writes_rd(in_op);
                    r_wb_rd    <= in_rd;
                    r_wb_data  <= in_data;
                end
            end else if (r_state == ISSUE && mem_gnt) begin
                r_k <= r_k + 3'd1;
            end
        end
    end

    // Access datapath: only observed in ISSUE/DRAIN/DONE, so no reset needed.
    // The byte granted in cycle t arrives on mem_din in t+1 and is steered by r_cap_idx.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (w_accept_mem) begin
                r_op   <= in_op;
                r_addr <= in_addr;
                r_data <= in_data;
                r_rd   <= in_rd;
            end
            r_cap_idx <= r_k[1:0];
            if (r_cap_pend) begin
                r_buf[{r_cap_idx, 3'b000} +: 8] <= mem_din;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = False;
        mem_wr      = False;
        mem_a       = '0;
        mem_dout    = 8'h00;
        mem_stall   = False;
        wb_valid    = r_wb_valid;
        wb_we       = r_wb_we;
        wb_rd       = r_wb_rd;
        wb_data     = r_wb_data;
        case (r_state)
            IDLE: begin
                if (w_accept_mem) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_req   = True;
                mem_wr    = op_is_store(r_op) && mem_gnt && rdy;
                mem_a     = r_addr + ADDR_W'(r_k);
                mem_dout  = r_data[{r_k[1:0], 3'b000} +: 8];
                mem_stall = True;
                if (mem_gnt && (r_k == w_last_k)) begin
                    w_state_nxt = op_is_store(r_op) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                mem_stall   = True;
                w_state_nxt = DONE;
            end
            DONE: begin
                wb_valid    = True;
                wb_we       = op_is_load(r_op) && (r_rd != RegAddrZero);
                wb_rd       = r_rd;
                wb_data     = op_is_load(r_op) ? w_ext : DATA_W'(ZERO_WORD);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: byte-wide RAM model, expected writes and
// writeback results queued at issue, popped by a negedge monitor.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        in_valid;
    op_t         in_op;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_stall;

    mem_access #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr), .in_data(in_data), .in_rd(in_rd),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_stall(mem_stall)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_rd;
    } wb_exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    wb_exp_t wb_q[$];
    wr_exp_t wr_q[$];
    wb_exp_t wb_e;
    wr_exp_t wr_e;
    int      n_checks = 0;
    int      n_pass   = 0;
    logic [7:0] ram [0:4095];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 1-cycle read latency, frozen with the rest of the core when rdy is low.
    always @(posedge clk) begin
        if (rdy && mem_req && mem_gnt) begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    always @(negedge clk) begin
        if (wb_valid) begin
            n_checks++;
            if (wb_q.size() == 0) begin
                $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%08h, required no result", wb_rd, wb_data);
            end else begin
                wb_e = wb_q.pop_front();
                if (wb_we === wb_e.we && wb_data === wb_e.data && (!wb_e.chk_rd || wb_rd === wb_e.rd))
                    n_pass++;
                else
                    $display("FAIL wb_result: got we=%0b rd=%0d data=0x%08h, required we=%0b rd=%0d data=0x%08h",
                             wb_we, wb_rd, wb_data, wb_e.we, wb_e.rd, wb_e.data);
            end
        end
        if (mem_wr) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                $display("FAIL wr_unexpected: got write 0x%02h@0x%08h, required no write", mem_dout, mem_a);
            end else begin
                wr_e = wr_q.pop_front();
                if (mem_a === wr_e.a && mem_dout === wr_e.d)
                    n_pass++;
                else
                    $display("FAIL wr_byte: got 0x%02h@0x%08h, required 0x%02h@0x%08h", mem_dout, mem_a, wr_e.d, wr_e.a);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic exp_wb(input logic we, input logic [4:0] rd, input logic [31:0] d, input logic chk_rd);
        wb_q.push_back('{we, rd, d, chk_rd});
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [31:0] w, input int n);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            wr_q.push_back('{ai, w[8*i +: 8]});
        end
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic drive(input op_t op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        @(posedge clk); #1;
        in_op = op; in_addr = a; in_data = d; in_rd = rd; in_valid = 1'b1;
    endtask

    task automatic wait_wb(input string name, input int lat0, input int exp_lat, input bit is_mem);
        int lat;
        int nostall;
        bit seen;
        lat = lat0; nostall = 0; seen = 1'b0;
        while (!seen && lat < lat0 + 40) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (wb_valid) seen = 1'b1;
            else if (is_mem && !mem_stall) nostall++;
        end
        chk({name, " wb seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " stall at wb"}, 32'(mem_stall), 32'd0);
        chk({name, " req at wb"}, 32'(mem_req), 32'd0);
        if (is_mem) chk({name, " stall held"}, nostall, 0);
    endtask

    task automatic do_op(input string name, input op_t op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input int exp_lat, input bit is_mem);
        drive(op, a, d, rd);
        wait_wb(name, 0, exp_lat, is_mem);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int lat;
        rst_n = 1'b0; rdy = 1'b1; mem_gnt = 1'b1; in_valid = 1'b0;
        in_op = OP_NOP; in_addr = '0; in_data = '0; in_rd = '0;
        #2;
        chk("reset ctrl", {27'd0, mem_req, mem_wr, wb_valid, wb_we, mem_stall}, 32'd0);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset dout/rd", {19'd0, mem_dout, wb_rd}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pass-through ops
        exp_wb(1'b1, 5'd5, 32'h0000_1234, 1'b1);
        do_op("ADD", OP_ADD, 32'h0, 32'h0000_1234, 5'd5, 1, 1'b0);
        exp_wb(1'b0, 5'd0, 32'hDEAD_BEEF, 1'b1);
        do_op("ADD x0", OP_ADD, 32'h0, 32'hDEAD_BEEF, 5'd0, 1, 1'b0);
        exp_wb(1'b0, 5'd7, 32'h0000_0001, 1'b1);
        do_op("BEQ", OP_BEQ, 32'h0, 32'h0000_0001, 5'd7, 1, 1'b0);

        // SW with continuous grant, byte-by-byte checks
        w = 32'hA1B2_C3D4;
        exp_store(32'h100, w, 4);
        drive(OP_SW, 32'h100, w, 5'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("SW addr %0d", i), mem_a, 32'h100 + 32'(i));
            chk($sformatf("SW wr/dout %0d", i), {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, w[8*i +: 8]});
            if (i < 3) begin
                @(posedge clk); #1;
                lat++;
            end
        end
        wait_wb("SW", lat, 5, 1'b1);

        // Byte stores, then sign/zero-extended loads
        exp_store(32'h200, 32'h0000_0080, 1);
        do_op("SB 200", OP_SB, 32'h200, 32'h0000_0080, 5'd0, 2, 1'b1);
        exp_store(32'h201, 32'h0000_0034, 1);
        do_op("SB 201", OP_SB, 32'h201, 32'h0000_0034, 5'd0, 2, 1'b1);
        exp_store(32'h202, 32'h0000_0092, 1);
        do_op("SB 202", OP_SB, 32'h202, 32'h0000_0092, 5'd0, 2, 1'b1);
        exp_wb(1'b1, 5'd1, 32'hFFFF_FF80, 1'b1);
        do_op("LB", OP_LB, 32'h200, 32'h0, 5'd1, 3, 1'b1);
        exp_wb(1'b1, 5'd2, 32'h0000_0080, 1'b1);
        do_op("LBU", OP_LBU, 32'h200, 32'h0, 5'd2, 3, 1'b1);
        exp_wb(1'b1, 5'd3, 32'hFFFF_9234, 1'b1);
        do_op("LH", OP_LH, 32'h201, 32'h0, 5'd3, 4, 1'b1);
        exp_wb(1'b1, 5'd4, 32'h0000_9234, 1'b1);
        do_op("LHU", OP_LHU, 32'h201, 32'h0, 5'd4, 4, 1'b1);
        exp_wb(1'b1, 5'd6, 32'hA1B2_C3D4, 1'b1);
        do_op("LW", OP_LW, 32'h100, 32'h0, 5'd6, 6, 1'b1);

        // Wrapping store, then wrapping load with grant withheld on byte 1
        exp_store(32'hFFFF_FFFE, 32'h4433_2211, 4);
        do_op("SW wrap", OP_SW, 32'hFFFF_FFFE, 32'h4433_2211, 5'd0, 5, 1'b1);
        exp_wb(1'b1, 5'd9, 32'h4433_2211, 1'b1);
        drive(OP_LW, 32'hFFFF_FFFE, 32'h0, 5'd9);
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("LWg addr0", mem_a, 32'hFFFF_FFFE);
        chk("LWg req/stall", {30'd0, mem_req, mem_stall}, 32'd3);
        @(posedge clk); #1 mem_gnt = 1'b0;
        lat++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("LWg addr1 hold %0d", i), mem_a, 32'hFFFF_FFFF);
            chk($sformatf("LWg wr/stall %0d", i), {30'd0, mem_wr, mem_stall}, 32'd1);
            @(posedge clk); #1;
            lat++;
            if (i == 1) mem_gnt = 1'b1;
        end
        @(negedge clk);
        chk("LWg addr2", mem_a, 32'h0000_0000);
        @(posedge clk); #1;
        lat++;
        @(negedge clk);
        chk("LWg addr3", mem_a, 32'h0000_0001);
        wait_wb("LWg", lat, 8, 1'b1);

        // Reset in the middle of a halfword store
        exp_store(32'h401, 32'h0000_005A, 1);
        do_op("SB 401", OP_SB, 32'h401, 32'h0000_005A, 5'd0, 2, 1'b1);
        wr_q.push_back('{32'h400, 8'hEF});
        drive(OP_SH, 32'h400, 32'h0000_BEEF, 5'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("SHr byte0", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'hEF});
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("SHr ctrl zero", {27'd0, mem_req, mem_wr, wb_valid, wb_we, mem_stall}, 32'd0);
        chk("SHr addr zero", mem_a, 32'd0);
        chk("SHr dout zero", {24'd0, mem_dout}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("SHr idle after", {30'd0, mem_req, mem_stall}, 32'd0);
        exp_wb(1'b1, 5'd10, 32'h0000_005A, 1'b1);
        do_op("LBU 401", OP_LBU, 32'h401, 32'h0, 5'd10, 3, 1'b1);
        exp_wb(1'b1, 5'd11, 32'h0000_00EF, 1'b1);
        do_op("LBU 400", OP_LBU, 32'h400, 32'h0, 5'd11, 3, 1'b1);

        // LW to x0 with rdy low for 3 cycles mid-access
        exp_store(32'h300, 32'h1234_5678, 4);
        do_op("SW 300", OP_SW, 32'h300, 32'h1234_5678, 5'd0, 5, 1'b1);
        exp_wb(1'b0, 5'd0, 32'h1234_5678, 1'b1);
        drive(OP_LW, 32'h300, 32'h0, 5'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 1;
        @(posedge clk); #1 rdy = 1'b0;
        lat++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("LWr addr hold %0d", i), mem_a, 32'h301);
            chk($sformatf("LWr frozen %0d", i), {28'd0, mem_req, mem_stall, mem_wr, wb_valid}, 32'hC);
            @(posedge clk); #1;
            lat++;
            if (i == 2) rdy = 1'b1;
        end
        wait_wb("LWr", lat, 9, 1'b1);

        repeat (4) @(negedge clk);
        chk("wb queue drained", wb_q.size(), 32'd0);
        chk("wr queue drained", wr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the RV32I pipeline; consumes the EX-stage result bundle (op, effective address, store data/ALU result, rd).
- Non-memory ops pass through to writeback in one cycle.
- Loads/stores execute byte-serially on the 8-bit unified RAM port (1-cycle read latency) behind the fetch/data arbiter. Load results are sign- or zero-extended; pipeline stall is asserted while an access is in flight.

Parameters:
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, register/data width
- RD_LAT, 1, RAM read latency in cycles (only 1 supported; checked at elaboration)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low freezes all state, outputs held
- in_valid  in  1  EX/MEM latch carries a new instruction this cycle
- in_op  in  OpLen  decoded op (shared op constants)
- in_addr  in  ADDR_W  effective address (reg1+Imm)
- in_data  in  DATA_W  ALU result, or store data for SB/SH/SW
- in_rd  in  5  destination register
- mem_req  out  1  request RAM port from arbiter
- mem_gnt  in  1  arbiter grant, valid same cycle
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1=write byte this cycle
- mem_dout  out  8  write byte
- mem_din  in  8  read byte for address issued previous granted cycle
- wb_valid  out  1  one-cycle pulse: result complete
- wb_we  out  1  register write enable (0 for stores, branches, rd==0)
- wb_rd  out  5  writeback register
- wb_data  out  DATA_W  writeback value
- mem_stall  out  1  hold upstream stages

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req=0, mem_wr=0, mem_a=0, mem_dout=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, mem_stall=0. A reset mid-access aborts it; no further byte is written and no result is produced.
- rdy=0: no state change, all registered outputs hold; takes precedence over every event below.
- Size N: LB/LBU/SB=1, LH/LHU/SH=2, LW/SW=4.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, in_valid, non-memory op: next cycle wb_valid=1, wb_data=in_data, wb_rd=in_rd, wb_we=(in_rd!=0 and op writes rd); mem_stall stays 0.
- IDLE, in_valid, load/store: latch op/addr/data/rd, byte index k=0, mem_stall=1 from the next cycle, go to ISSUE.
- ISSUE: mem_req=1, mem_a=addr+k (mod 2^ADDR_W, wraps at 0xFFFFFFFF→0), mem_wr=store, mem_dout=data[8k+7:8k].
  - Granted cycle: k increments.
  - Not granted: mem_a/mem_wr/k hold and mem_wr is forced 0.
  - After byte N-1 is granted: stores go to DONE; loads go to DRAIN.
- Load byte collection: the byte issued in granted cycle t is captured from mem_din at t+1 into buf[8j+7:8j], independent of the grant in t+1.
- DRAIN: mem_req=0, mem_wr=0; capture the last byte; → DONE.
- DONE: wb_valid=1 for one cycle, mem_stall=0, → IDLE. in_valid in DONE is ignored; upstream re-presents while stalled.
- Load extension:
  - LB sign-extends buf[7]; LH sign-extends buf[15]; LBU/LHU zero-extend; LW takes buf verbatim.
  - Little-endian: byte 0 lands at LSB. No alignment requirement.
- Stores: wb_we=0, wb_data=0.
- Latency with continuous grant: load N+2 cycles from acceptance to wb_valid, store N+1, non-memory 1.
- Outside ISSUE, mem_wr is never 1.

Decomposition:
- Shared config package: OpLen and all op encodings, ZERO_WORD, RegAddrZero, True/False, plus new size/load-extend helper constants.
- One natural sub-module: mem_load_ext. It is combinational (op, buf) → extended word, reusable by a future data cache.

Test Plan:
- ADD, in_data=0x1234, rd=5 → next cycle wb_valid=1, wb_we=1, wb_data=0x1234, no mem_req.
- SW, addr=0x100, data=0xA1B2C3D4, gnt=1 → writes D4@0x100, C3@0x101, B2@0x102, A1@0x103 on consecutive cycles; wb_valid 5 cycles after accept, wb_we=0.
- LB at 0x200 holding 0x80 → wb_data=0xFFFFFF80; LBU same byte → 0x00000080; LH at 0x201 (bytes 0x34,0x92) → 0xFFFF9234.
- LW at 0xFFFFFFFE with gnt low on the 2nd byte for 2 cycles → addresses 0xFFFFFFFE, 0xFFFFFFFF (held 3 cycles, mem_wr=0), 0x0, 0x1; correct word assembled; mem_stall held throughout.
- SH in flight, rst_n low after first byte → all outputs 0 immediately, second byte never written, no wb_valid after release.
- LW to rd=0 with rdy low for 3 cycles mid-access → outputs frozen, resumes; wb_valid=1, wb_we=0.
